vga_layer_mixer: RTL and testbench
==================================

Name: vga_layer_mixer

Overview:
- Parametrised final pixel stage for the VGA pipeline. Sits after the last draw stage (background, falling block, fallen blocks) and drives the board pins.
- Replaces the single fixed output register with a priority compositor over LAYERS concatenated RGB inputs.
- Adds a colour-key transparency test per pixel.
- Adds frame-synchronous layer enables.
- Adds a per-frame overlap-pixel counter for game logic and debug.
- Keeps all timing signals aligned through a fixed 2-cycle pipeline.

Parameters:
- LAYERS, 3: number of RGB layers. Layer 0 is the base and has the lowest priority.
- CH_W, 4: bits per colour channel. One pixel is RGB_W = 3*CH_W bits.
- KEY_RGB, 12'h000: colour key. A layer pixel equal to KEY_RGB is transparent. Layer 0 is never keyed.
- BG_RGB, 12'h000: colour output when no enabled layer is opaque.
- EN_RST, {LAYERS{1'b1}}: active layer enables after reset.
- CNT_W, 20: overlap counter width. Sized for 1024x768.

Ports:
- pclk  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- hcount_in  in  11  horizontal count, aligned with rgb_in
- vcount_in  in  11  vertical count
- hsync_in  in  1  horizontal sync
- vsync_in  in  1  vertical sync
- hblnk_in  in  1  horizontal blanking
- vblnk_in  in  1  vertical blanking
- rgb_in  in  LAYERS*RGB_W  layer pixels; layer i occupies bits [i*RGB_W +: RGB_W]
- layer_en  in  LAYERS  requested layer enables
- hs  out  1  registered hsync
- vs  out  1  registered vsync
- rgb_out  out  RGB_W  composited pixel, split by the top level into r/g/b
- hcount_out  out  11  delayed hcount
- vcount_out  out  11  delayed vcount
- overlap_cnt  out  CNT_W  overlap pixel count of the previous frame
- overlap_vld  out  1  one-cycle pulse when overlap_cnt updates

Behaviour:
- Single clock pclk. All state resets synchronously on rst=1.
- Reset values:
  - All outputs 0.
  - Active enable register = EN_RST.
  - Overlap accumulator 0.
  - vsync edge register 0.
- Latency: exactly 2 pclk from any *_in to the matching output, for timing and pixel alike.
- Stage 1:
  - opaque[i] = en_act[i] & (i==0 | pix_i != KEY_RGB).
  - sel = index of the highest set bit of opaque.
  - any = |opaque.
  - multi = popcount(opaque) >= 2.
  - blank = hblnk_in | vblnk_in.
  - Register sel, any, multi, blank, all layer pixels and all timing signals.
- Stage 2:
  - rgb_out = blank ? 0 : (any ? pix_sel : BG_RGB).
  - hs, vs, hcount_out and vcount_out take the stage-1 values.
- Frame edge: vs_rise = vsync_in & ~vsync_q, where vsync_q is vsync_in registered.
- Enables:
  - en_act loads layer_en only on a vs_rise cycle.
  - Changes to layer_en at any other time have no effect until the next frame. This prevents tearing.
  - The pixel on the vs_rise cycle already uses the new enables; it is in blanking, so this is invisible.
- Overlap counter:
  - The accumulator increments on each stage-1 cycle with multi=1 and blank=0.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - On vs_rise: overlap_cnt <= accumulator, accumulator <= 0, overlap_vld <= 1 for one cycle.
- Simultaneous events:
  - If an increment coincides with vs_rise, the clear wins. This cycle is blanked, so no increment is valid anyway.
  - If rst coincides with vs_rise, rst wins.
- Reset mid-frame:
  - Outputs are 0 on the cycle after rst.
  - The first overlap_vld after reset reports a partial frame. Consumers discard it.
- LAYERS=1 is legal: no overlap is possible, so overlap_cnt stays 0.

Decomposition:
- Shared package vga_pkg:
  - Constants: CH_W, RGB_W, timing widths (11), colour constants (KEY/BG defaults).
  - Function pixel_slice(bus, idx).
- Sub-module layer_prio_enc (parametrised LAYERS), used in stage 1:
  - Inputs: opaque vector.
  - Outputs: sel index ($clog2(LAYERS), min 1 bit), any, multi.
  - Purely combinational.

Test Plan:
- Reset: assert rst for 3 cycles mid-line with arbitrary inputs.
  - Required: cycle after the first rst edge shows hs=vs=0, rgb_out=0, hcount_out=0, overlap_cnt=0, overlap_vld=0.
- Priority and latency: LAYERS=3, layers = {12'hF00 (L2), 12'h0F0 (L1), 12'h00F (L0)}, all enabled, visible pixel at hcount=100.
  - Required: rgb_out=12'hF00 and hcount_out=100 exactly 2 cycles later.
  - Then L2=KEY gives 12'h0F0; L2=L1=KEY gives 12'h00F.
- Blanking: same pixels with hblnk_in=1.
  - Required: rgb_out=0 two cycles later.
  - hs/vs follow their inputs with 2-cycle delay.
- Frame-synchronous enable: drive layer_en=3'b001 mid-frame.
  - Required: output stays 12'hF00 until the next vsync_in rising edge, then 12'h00F.
  - layer_en=3'b000 after the next edge: BG_RGB.
- Overlap count: 1 frame with exactly 37 visible pixels where L1 and L2 are both opaque.
  - Required: overlap_vld pulses once at the next vs_rise with overlap_cnt=37.
  - Next frame with no overlap reports 0.
- Saturation: CNT_W=4, 20 overlapping visible pixels in one frame.
  - Required: overlap_cnt=15 at the next vs_rise.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and pixel helpers for the VGA output pipeline.
// Widths here are defaults; the mixer re-derives its own from its parameters.
package vga_pkg;

    localparam int DEF_CH_W  = 4;
    localparam int DEF_RGB_W = 3 * DEF_CH_W;
    localparam int TIM_W     = 11;

    localparam logic [DEF_RGB_W-1:0] DEF_KEY_RGB = 12'h000;
    localparam logic [DEF_RGB_W-1:0] DEF_BG_RGB  = 12'h000;

    // Upper bounds for the generic slicing helper (8 layers of 8-bit channels).
    localparam int MAX_LAYERS = 8;
    localparam int MAX_RGB_W  = 24;
    localparam int MAX_BUS_W  = MAX_LAYERS * MAX_RGB_W;

    // Returns pixel idx of a bus packed with rgb_w-bit pixels, zero-padded to MAX_RGB_W.
    function automatic logic [MAX_RGB_W-1:0] pixel_slice(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   idx,
        input int                   rgb_w
    );
        logic [MAX_BUS_W-1:0] shifted;
        logic [MAX_RGB_W-1:0] mask;
        shifted = bus >> (idx * rgb_w);
        mask    = {MAX_RGB_W{1'b1}} >> (MAX_RGB_W - rgb_w);
        return shifted[MAX_RGB_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/layer_prio_enc.sv
// Priority encoder over the opaque-layer vector: highest opaque layer wins.
// Also flags whether any layer is opaque and whether two or more overlap.
module layer_prio_enc #(
    parameter int LAYERS = 3,
    parameter int SEL_W  = (LAYERS > 1) ? $clog2(LAYERS) : 1
) (
    input  logic [LAYERS-1:0] i_opaque,
    output logic [SEL_W-1:0]  o_sel,
    output logic              o_any,
    output logic              o_multi
);

    always_comb begin
        o_sel = '0;
        for (int i = 0; i < LAYERS; i++) begin
            if (i_opaque[i]) begin
                o_sel = SEL_W'(i);
            end
        end
    end

    assign o_any   = |i_opaque;
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    assign o_multi = |(i_opaque & (i_opaque - 1'b1));

endmodule

// File: rtl/vga_layer_mixer.sv
// Final VGA pixel stage: keyed priority compositor over LAYERS inputs, frame-synchronous
// layer enables and a per-frame overlap counter, all on a fixed 2-cycle pipeline.
module vga_layer_mixer
    import vga_pkg::*;
#(
    parameter int                LAYERS  = 3,
    parameter int                CH_W    = DEF_CH_W,
    parameter logic [3*CH_W-1:0] KEY_RGB = DEF_KEY_RGB,
    parameter logic [3*CH_W-1:0] BG_RGB  = DEF_BG_RGB,
    parameter logic [LAYERS-1:0] EN_RST  = {LAYERS{1'b1}},
    parameter int                CNT_W   = 20
) (
    input  logic                     pclk,
    input  logic                     rst,
    input  logic [TIM_W-1:0]         hcount_in,
    input  logic [TIM_W-1:0]         vcount_in,
    input  logic                     hsync_in,
    input  logic                     vsync_in,
    input  logic                     hblnk_in,
    input  logic                     vblnk_in,
    input  logic [LAYERS*3*CH_W-1:0] rgb_in,
    input  logic [LAYERS-1:0]        layer_en,
    output logic                     hs,
    output logic                     vs,
    output logic [3*CH_W-1:0]        rgb_out,
    output logic [TIM_W-1:0]         hcount_out,
    output logic [TIM_W-1:0]         vcount_out,
    output logic [CNT_W-1:0]         overlap_cnt,
    output logic                     overlap_vld
);

    localparam int RGB_W = 3 * CH_W;
    localparam int BUS_W = LAYERS * RGB_W;
    localparam int SEL_W = (LAYERS > 1) ? $clog2(LAYERS) : 1;

    logic                 r_vsync_q;
    logic                 w_vs_rise;
    logic [LAYERS-1:0]    r_en_act;
    logic [LAYERS-1:0]    w_en_use;
    logic [LAYERS-1:0]    w_opaque;
    logic [MAX_BUS_W-1:0] w_bus_in;
    logic [MAX_RGB_W-1:0] w_layer_pix;

    logic [SEL_W-1:0]     w_sel;
    logic                 w_any;
    logic                 w_multi;

    // Stage 1 registers
    logic [SEL_W-1:0]     r_sel;
    logic                 r_any;
    logic                 r_multi;
    logic                 r_blank;
    logic [BUS_W-1:0]     r_pix;
    logic                 r_hs1;
    logic                 r_vs1;
    logic [TIM_W-1:0]     r_hc1;
    logic [TIM_W-1:0]     r_vc1;

    // Stage 2 registers
    logic [MAX_BUS_W-1:0] w_bus_q;
    logic [MAX_RGB_W-1:0] w_pix_sel;
    logic [RGB_W-1:0]     w_rgb_next;
    logic                 r_hs2;
    logic                 r_vs2;
    logic [TIM_W-1:0]     r_hc2;
    logic [TIM_W-1:0]     r_vc2;
    logic [RGB_W-1:0]     r_rgb2;

    logic [CNT_W-1:0]     r_acc;
    logic [CNT_W-1:0]     r_ov_cnt;
    logic                 r_ov_vld;
    logic                 w_unused_pad;

    assign w_vs_rise = vsync_in & ~r_vsync_q;
    // The vs_rise pixel already sees the new enables; it sits in blanking.
    assign w_en_use  = w_vs_rise ? layer_en : r_en_act;

    always_comb begin
        w_bus_in              = '0;
        w_bus_in[BUS_W-1:0]   = rgb_in;
        w_layer_pix           = '0;
        w_opaque              = '0;
        for (int i = 0; i < LAYERS; i++) begin
            w_layer_pix = pixel_slice(w_bus_in, i, RGB_W);
            w_opaque[i] = w_en_use[i] & ((i == 0) || (w_layer_pix[RGB_W-1:0] != KEY_RGB));
        end
    end

    layer_prio_enc #(
        .LAYERS (LAYERS),
        .SEL_W  (SEL_W)
    ) u_prio (
        .i_opaque (w_opaque),
        .o_sel    (w_sel),
        .o_any    (w_any),
        .o_multi  (w_multi)
    );

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_vsync_q <= 1'b0;
            r_en_act  <= EN_RST;
        end else begin
            r_vsync_q <= vsync_in;
            if (w_vs_rise) begin
                r_en_act <= layer_en;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_sel   <= '0;
            r_any   <= 1'b0;
            r_multi <= 1'b0;
            r_blank <= 1'b0;
            r_pix   <= '0;
            r_hs1   <= 1'b0;
            r_vs1   <= 1'b0;
            r_hc1   <= '0;
            r_vc1   <= '0;
        end else begin
            r_sel   <= w_sel;
            r_any   <= w_any;
            r_multi <= w_multi;
            r_blank <= hblnk_in | vblnk_in;
            r_pix   <= rgb_in;
            r_hs1   <= hsync_in;
            r_vs1   <= vsync_in;
            r_hc1   <= hcount_in;
            r_vc1   <= vcount_in;
        end
    end

    always_comb begin
        w_bus_q            = '0;
        w_bus_q[BUS_W-1:0] = r_pix;
        w_pix_sel          = pixel_slice(w_bus_q, int'(r_sel), RGB_W);
        if (r_blank) begin
            w_rgb_next = '0;
        end else if (r_any) begin
            w_rgb_next = w_pix_sel[RGB_W-1:0];
        end else begin
            w_rgb_next = BG_RGB;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            r_hs2  <= 1'b0;
            r_vs2  <= 1'b0;
            r_hc2  <= '0;
            r_vc2  <= '0;
            r_rgb2 <= '0;
        end else begin
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_hc2  <= r_hc1;
            r_vc2  <= r_vc1;
            r_rgb2 <= w_rgb_next;
        end
    end

    // Frame clear takes priority over a coincident increment.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_acc    <= '0;
            r_ov_cnt <= '0;
            r_ov_vld <= 1'b0;
        end else begin
            r_ov_vld <= w_vs_rise;
            if (w_vs_rise) begin
                r_ov_cnt <= r_acc;
                r_acc    <= '0;
            end else if (r_multi && !r_blank && (r_acc != {CNT_W{1'b1}})) begin
                r_acc <= r_acc + 1'b1;
            end
        end
    end

    assign w_unused_pad = ^{w_pix_sel, w_layer_pix};

    assign hs          = r_hs2;
    assign vs          = r_vs2;
    assign hcount_out  = r_hc2;
    assign vcount_out  = r_vc2;
    assign rgb_out     = r_rgb2;
    assign overlap_cnt = r_ov_cnt;
    assign overlap_vld = r_ov_vld;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Scoreboard bench for vga_layer_mixer: a 20-bit counter instance and a 4-bit
// saturating-counter instance share one stimulus stream.
module tb_vga_layer_mixer;

    localparam int EW = 36;
    localparam logic [35:0] FULL   = {12'hF00, 12'h0F0, 12'h00F};
    localparam logic [35:0] L1L0   = {12'h000, 12'h0F0, 12'h00F};
    localparam logic [35:0] L0ONLY = {12'h000, 12'h000, 12'h00F};

    logic        pclk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] hcount_in = '0;
    logic [10:0] vcount_in = '0;
    logic        hsync_in = 1'b0;
    logic        vsync_in = 1'b0;
    logic        hblnk_in = 1'b0;
    logic        vblnk_in = 1'b0;
    logic [35:0] rgb_in = '0;
    logic [2:0]  layer_en = 3'b111;

    logic        hs, vs, overlap_vld;
    logic [11:0] rgb_out;
    logic [10:0] hcount_out, vcount_out;
    logic [19:0] overlap_cnt;

    logic        s_hs, s_vs, s_vld;
    logic [11:0] s_rgb;
    logic [10:0] s_hc, s_vc;
    logic [3:0]  s_cnt;

    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          done = 1'b0;
    bit          finished = 1'b0;
    logic [10:0] cur_vc = 11'd10;

    logic [EW-1:0] exp_q[$];
    int            due_q[$];
    bit            rchk_q[$];
    logic [19:0]   ov_q[$];
    logic [3:0]    ovs_q[$];

    logic [EW-1:0] e_val;
    int            e_due;
    bit            e_rst;
    logic [19:0]   e_ov;
    logic [3:0]    e_ovs;

    vga_layer_mixer dut (
        .pclk (pclk), .rst (rst),
        .hcount_in (hcount_in), .vcount_in (vcount_in),
        .hsync_in (hsync_in), .vsync_in (vsync_in),
        .hblnk_in (hblnk_in), .vblnk_in (vblnk_in),
        .rgb_in (rgb_in), .layer_en (layer_en),
        .hs (hs), .vs (vs), .rgb_out (rgb_out),
        .hcount_out (hcount_out), .vcount_out (vcount_out),
        .overlap_cnt (overlap_cnt), .overlap_vld (overlap_vld)
    );

    vga_layer_mixer #(.CNT_W(4)) dut_sat (
        .pclk (pclk), .rst (rst),
        .hcount_in (hcount_in), .vcount_in (vcount_in),
        .hsync_in (hsync_in), .vsync_in (vsync_in),
        .hblnk_in (hblnk_in), .vblnk_in (vblnk_in),
        .rgb_in (rgb_in), .layer_en (layer_en),
        .hs (s_hs), .vs (s_vs), .rgb_out (s_rgb),
        .hcount_out (s_hc), .vcount_out (s_vc),
        .overlap_cnt (s_cnt), .overlap_vld (s_vld)
    );

    // Clock and cycle counter
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic push_exp(input logic [EW-1:0] v, input int d, input bit r);
        exp_q.push_back(v);
        due_q.push_back(d);
        rchk_q.push_back(r);
    endtask

    // One pixel cycle; the expected output lands two cycles later.
    task automatic step(input logic [10:0] hc, input logic hb, input logic vb,
                        input logic hsv, input logic vsv,
                        input logic [35:0] pix, input logic [11:0] erg);
        hcount_in = hc;
        vcount_in = cur_vc;
        hblnk_in  = hb;
        vblnk_in  = vb;
        hsync_in  = hsv;
        vsync_in  = vsv;
        rgb_in    = pix;
        push_exp({hsv, vsv, hc, cur_vc, erg}, cyc + 2, 1'b0);
        @(posedge pclk);
        #1;
    endtask

    // Blanked vsync pulse; both instances report their frame counts on the rise.
    task automatic frame_edge(input logic [19:0] e_main, input logic [3:0] e_sat);
        ov_q.push_back(e_main);
        ovs_q.push_back(e_sat);
        step(11'd0, 1'b1, 1'b1, 1'b0, 1'b0, FULL, 12'h000);
        step(11'd1, 1'b1, 1'b1, 1'b0, 1'b1, FULL, 12'h000);
        step(11'd2, 1'b1, 1'b1, 1'b1, 1'b1, FULL, 12'h000);
        step(11'd3, 1'b1, 1'b1, 1'b1, 1'b0, FULL, 12'h000);
        cur_vc = cur_vc + 11'd1;
    endtask

    initial begin
        repeat (2) @(posedge pclk);
        #1;
        // Reset mid-line with arbitrary inputs
        rst       = 1'b1;
        hcount_in = 11'd37;
        vcount_in = 11'd5;
        hsync_in  = 1'b1;
        rgb_in    = FULL;
        repeat (3) begin
            push_exp('0, cyc + 1, 1'b1);
            @(posedge pclk);
            #1;
        end
        rst = 1'b0;

        // Priority and keying
        step(11'd100, 1'b0, 1'b0, 1'b0, 1'b0, FULL,   12'hF00);
        step(11'd101, 1'b0, 1'b0, 1'b0, 1'b0, L1L0,   12'h0F0);
        step(11'd102, 1'b0, 1'b0, 1'b0, 1'b0, L0ONLY, 12'h00F);

        // Blanking, with hs/vs alignment
        step(11'd103, 1'b1, 1'b0, 1'b1, 1'b0, FULL, 12'h000);
        step(11'd104, 1'b0, 1'b1, 1'b0, 1'b0, FULL, 12'h000);
        step(11'd105, 1'b1, 1'b0, 1'b1, 1'b0, FULL, 12'h000);

        // Enable change mid-frame has no effect until the next vsync rise
        layer_en = 3'b001;
        step(11'd110, 1'b0, 1'b0, 1'b0, 1'b0, FULL, 12'hF00);
        step(11'd111, 1'b0, 1'b0, 1'b0, 1'b0, FULL, 12'hF00);
        frame_edge(20'd4, 4'd4);
        step(11'd100, 1'b0, 1'b0, 1'b0, 1'b0, FULL, 12'h00F);
        layer_en = 3'b000;
        step(11'd101, 1'b0, 1'b0, 1'b0, 1'b0, FULL, 12'h00F);
        frame_edge(20'd0, 4'd0);
        step(11'd100, 1'b0, 1'b0, 1'b0, 1'b0, FULL,   12'h000);
        step(11'd101, 1'b0, 1'b0, 1'b0, 1'b0, L0ONLY, 12'h000);
        layer_en = 3'b111;
        frame_edge(20'd0, 4'd0);

        // 37 visible overlap pixels, interleaved with blanked and single-layer pixels
        for (int i = 0; i < 37; i++) begin
            step(11'(100 + i), 1'b0, 1'b0, 1'b0, 1'b0, FULL, 12'hF00);
            if (i % 6 == 0) begin
                step(11'(300 + i), 1'b1, 1'b0, 1'b1, 1'b0, FULL, 12'h000);
                step(11'(400 + i), 1'b0, 1'b0, 1'b0, 1'b0, {24'h0, 12'h0A5}, 12'h0A5);
            end
        end
        frame_edge(20'd37, 4'd15);

        // Frame without overlap
        for (int i = 0; i < 10; i++) begin
            step(11'(200 + i), 1'b0, 1'b0, 1'b0, 1'b0, {24'h0, 12'h05A}, 12'h05A);
        end
        frame_edge(20'd0, 4'd0);

        // Saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            step(11'(500 + i), 1'b0, 1'b0, 1'b0, 1'b0, FULL, 12'hF00);
        end
        frame_edge(20'd20, 4'd15);
        frame_edge(20'd0, 4'd0);

        repeat (6) @(posedge pclk);
        #1;
        done = 1'b1;
    end

    // Monitor and scoreboard: all counts are stepped here only.
    always @(negedge pclk) begin
        if (!finished) begin
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                e_val = exp_q.pop_front();
                e_due = due_q.pop_front();
                e_rst = rchk_q.pop_front();
                total++;
                if (e_due != cyc) begin
                    bad++;
                    $display("FAIL pix_late: due cycle %0d seen at %0d", e_due, cyc);
                end else if ({hs, vs, hcount_out, vcount_out, rgb_out} !== e_val) begin
                    bad++;
                    $display("FAIL pix@%0d: got hs=%b vs=%b hc=%0d vc=%0d rgb=%h, exp hs=%b vs=%b hc=%0d vc=%0d rgb=%h",
                             cyc, hs, vs, hcount_out, vcount_out, rgb_out,
                             e_val[35], e_val[34], e_val[33:23], e_val[22:12], e_val[11:0]);
                end
                if (e_rst) begin
                    total++;
                    if (overlap_cnt !== 20'd0 || overlap_vld !== 1'b0) begin
                        bad++;
                        $display("FAIL rst_ovl@%0d: got cnt=%0d vld=%b, exp cnt=0 vld=0",
                                 cyc, overlap_cnt, overlap_vld);
                    end
                end
            end

            if (overlap_vld === 1'b1) begin
                total++;
                if (ov_q.size() == 0) begin
                    bad++;
                    $display("FAIL ovl_extra@%0d: pulse with cnt=%0d, exp no pulse", cyc, overlap_cnt);
                end else begin
                    e_ov = ov_q.pop_front();
                    if (overlap_cnt !== e_ov) begin
                        bad++;
                        $display("FAIL ovl_cnt@%0d: got %0d, exp %0d", cyc, overlap_cnt, e_ov);
                    end
                end
            end

            if (s_vld === 1'b1) begin
                total++;
                if (ovs_q.size() == 0) begin
                    bad++;
                    $display("FAIL sat_extra@%0d: pulse with cnt=%0d, exp no pulse", cyc, s_cnt);
                end else begin
                    e_ovs = ovs_q.pop_front();
                    if (s_cnt !== e_ovs) begin
                        bad++;
                        $display("FAIL sat_cnt@%0d: got %0d, exp %0d", cyc, s_cnt, e_ovs);
                    end
                end
            end

            if (done || cyc > 20000) begin
                if (!done) begin
                    total++;
                    bad++;
                    $display("FAIL timeout: stimulus unfinished at cycle %0d, exp done", cyc);
                end
                total++;
                if (due_q.size() != 0) begin
                    bad++;
                    $display("FAIL pix_left: %0d pending, exp 0", due_q.size());
                end
                total++;
                if (ov_q.size() != 0) begin
                    bad++;
                    $display("FAIL ovl_missing: %0d pulses not seen, exp 0", ov_q.size());
                end
                total++;
                if (ovs_q.size() != 0) begin
                    bad++;
                    $display("FAIL sat_missing: %0d pulses not seen, exp 0", ovs_q.size());
                end
                finished = 1'b1;
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

endmodule
